// File: rtl/decode_stage_pipe.sv
// Decode stage: field decode, 16-entry register file with write-through bypass,
// immediate extension and a decode/execute pipeline register with load-use interlock.
module decode_stage_pipe #(
  parameter int          N      = 32,
  parameter logic [3:0]  PC_REG = 4'd15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [31:0]  inst,
  input  logic [N-1:0] pc,
  input  logic         reg_src_a1,
  input  logic         reg_src_a2,
  input  logic [1:0]   imm_src,
  input  logic         reg_write,
  input  logic [3:0]   a3,
  input  logic [N-1:0] wd3,
  input  logic         ex_stall,
  input  logic         flush,
  output logic [3:0]   a1,
  output logic [3:0]   a2,
  output logic         stall_fd,
  output logic         out_valid,
  output logic [N-1:0] out_rd1,
  output logic [N-1:0] out_rd2,
  output logic [N-1:0] out_imm,
  output logic [3:0]   out_rd,
  output logic [2:0]   out_cond,
  output logic [1:0]   out_op,
  output logic [4:0]   out_cmd,
  output logic         out_imm_flag,
  output logic         out_mem_load,
  output logic [N-1:0] r0,
  output logic [N-1:0] r1
);

  typedef struct packed {
    logic         valid;
    logic [N-1:0] rd1;
    logic [N-1:0] rd2;
    logic [N-1:0] imm;
    logic [3:0]   rd;
    logic [2:0]   cond;
    logic [1:0]   op;
    logic [4:0]   cmd;
    logic         imm_flag;
    logic         mem_load;
  } de_reg_t;

  logic [N-1:0] regs [16];
  de_reg_t      de_q;
  de_reg_t      de_d;
  logic         wr_en;
  logic         load_use;

  assign a1    = reg_src_a1 ? PC_REG : inst[16:13];
  assign a2    = reg_src_a2 ? inst[20:17] : inst[3:0];
  assign wr_en = reg_write && (a3 != PC_REG);

  always_comb begin
    // NOTE: every output of this block is given a value up front so no path can infer a latch.
    de_d          = '0;
    de_d.valid    = in_valid;
    de_d.cond     = inst[31:29];
    de_d.op       = inst[28:27];
    de_d.imm_flag = inst[26];
    de_d.cmd      = inst[25:21];
    de_d.rd       = inst[20:17];
    de_d.mem_load = (inst[28:27] == 2'b01) && inst[21];

    // PC reads take precedence; PC_REG is never a bypass target since wr_en excludes it.
    if (a1 == PC_REG)               de_d.rd1 = pc;
    else if (wr_en && (a3 == a1))   de_d.rd1 = wd3;
    else                            de_d.rd1 = regs[a1];

    if (a2 == PC_REG)               de_d.rd2 = pc;
    else if (wr_en && (a3 == a2))   de_d.rd2 = wd3;
    else                            de_d.rd2 = regs[a2];

    case (imm_src)
      2'b00:   de_d.imm = N'(inst[7:0]);
      2'b01:   de_d.imm = N'(inst[11:0]);
      2'b10:   de_d.imm = N'($signed({inst[23:0], 2'b00}));
      default: de_d.imm = N'($signed(inst[25:0]));
    endcase
  end

  assign load_use = de_q.valid && de_q.mem_load && in_valid &&
                    (((de_q.rd == a1) && (a1 != PC_REG)) ||
                     ((de_q.rd == a2) && (a2 != PC_REG)));
  assign stall_fd = !flush && (ex_stall || load_use);

  // NOTE: the register file is flops that must read zero after reset, so it is cleared explicitly.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[a3] <= wd3;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush)  de_q <= '0;
    else if (ex_stall) de_q <= de_q;
    else if (load_use) de_q <= '0;
    else               de_q <= de_d;
  end

  assign out_valid    = de_q.valid;
  assign out_rd1      = de_q.rd1;
  assign out_rd2      = de_q.rd2;
  assign out_imm      = de_q.imm;
  assign out_rd       = de_q.rd;
  assign out_cond     = de_q.cond;
  assign out_op       = de_q.op;
  assign out_cmd      = de_q.cmd;
  assign out_imm_flag = de_q.imm_flag;
  assign out_mem_load = de_q.mem_load;
  assign r0           = regs[0];
  assign r1           = regs[1];

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: a table of single-cycle decode vectors
// followed by hand-written load-use, stall, flush and reset sequences.
module tb_decode_stage_pipe;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [31:0]  inst;
  logic [N-1:0] pc;
  logic         reg_src_a1, reg_src_a2;
  logic [1:0]   imm_src;
  logic         reg_write;
  logic [3:0]   a3;
  logic [N-1:0] wd3;
  logic         ex_stall, flush;
  logic [3:0]   a1, a2;
  logic         stall_fd, out_valid;
  logic [N-1:0] out_rd1, out_rd2, out_imm;
  logic [3:0]   out_rd;
  logic [2:0]   out_cond;
  logic [1:0]   out_op;
  logic [4:0]   out_cmd;
  logic         out_imm_flag, out_mem_load;
  logic [N-1:0] r0, r1;

  int checks = 0;
  int errors = 0;

  decode_stage_pipe #(.N(N), .PC_REG(4'd15)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .inst(inst), .pc(pc),
    .reg_src_a1(reg_src_a1), .reg_src_a2(reg_src_a2), .imm_src(imm_src),
    .reg_write(reg_write), .a3(a3), .wd3(wd3), .ex_stall(ex_stall), .flush(flush),
    .a1(a1), .a2(a2), .stall_fd(stall_fd), .out_valid(out_valid),
    .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm), .out_rd(out_rd),
    .out_cond(out_cond), .out_op(out_op), .out_cmd(out_cmd),
    .out_imm_flag(out_imm_flag), .out_mem_load(out_mem_load), .r0(r0), .r1(r1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        in_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        src_a1;
    logic        src_a2;
    logic [1:0]  imm_src;
    logic        reg_write;
    logic [3:0]  a3;
    logic [31:0] wd3;
    logic        exp_valid;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    logic [31:0] exp_imm;
    logic [3:0]  exp_rd;
    logic [2:0]  exp_cond;
    logic [1:0]  exp_op;
    logic [4:0]  exp_cmd;
    logic        exp_flag;
    logic        exp_load;
  } vec_t;

  function automatic logic [31:0] mk(input logic [2:0] c, input logic [1:0] o, input logic f,
                                     input logic [4:0] cm, input logic [3:0] d,
                                     input logic [3:0] n, input logic [3:0] s);
    return {c, o, f, cm, d, n, 9'b0, s};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0; inst = '0; pc = '0; reg_src_a1 = 1'b0; reg_src_a2 = 1'b0;
    imm_src = 2'b00; reg_write = 1'b0; a3 = '0; wd3 = '0; ex_stall = 1'b0; flush = 1'b0;
  endtask

  task automatic drive_dec(input logic [31:0] i);
    in_valid = 1'b1; inst = i; reg_src_a1 = 1'b0; reg_src_a2 = 1'b0; imm_src = 2'b00;
  endtask

  vec_t vecs[12];

  initial begin
    //           vld inst                           pc        a1 a2 imm wr a3  wd3        | vld rd1         rd2         imm          rd cond op cmd flag load
    vecs[0]  = '{1, mk(5, 2, 1, 6, 2, 0, 0),        32'h40,   0, 0, 0, 1, 3,  32'hAA,     1, 32'h0,       32'h0,      32'h0,       2, 5, 2, 6,  1, 0};
    vecs[1]  = '{1, mk(0, 0, 0, 2, 7, 3, 3),        32'h44,   0, 0, 1, 1, 8,  32'h55,     1, 32'hAA,      32'hAA,     32'h3,       7, 0, 0, 2,  0, 0};
    vecs[2]  = '{1, mk(7, 3, 0, 16, 1, 8, 5),       32'h48,   0, 0, 0, 1, 5,  32'h1234,   1, 32'h55,      32'h1234,   32'h5,       1, 7, 3, 16, 0, 0};
    vecs[3]  = '{1, mk(0, 0, 0, 0, 5, 2, 0),        32'h100,  1, 1, 0, 1, 15, 32'hFF,     1, 32'h100,     32'h1234,   32'h0,       5, 0, 0, 0,  0, 0};
    vecs[4]  = '{1, mk(0, 0, 0, 0, 0, 0, 15),       32'h104,  1, 0, 0, 1, 1,  32'hCAFE,   1, 32'h104,     32'h104,    32'hF,       0, 0, 0, 0,  0, 0};
    vecs[5]  = '{1, 32'h03FF_FFF0,                  32'h200,  0, 0, 3, 0, 0,  32'h0,      1, 32'h200,     32'h0,      32'hFFFF_FFF0, 15, 0, 0, 31, 0, 0};
    vecs[6]  = '{1, 32'h03FF_FFF0,                  32'h200,  0, 0, 2, 0, 0,  32'h0,      1, 32'h200,     32'h0,      32'hFFFF_FFC0, 15, 0, 0, 31, 0, 0};
    vecs[7]  = '{1, 32'h03FF_FFF0,                  32'h200,  0, 0, 0, 0, 0,  32'h0,      1, 32'h200,     32'h0,      32'h0000_00F0, 15, 0, 0, 31, 0, 0};
    vecs[8]  = '{1, 32'h03FF_FFF0,                  32'h200,  0, 0, 1, 0, 0,  32'h0,      1, 32'h200,     32'h0,      32'h0000_0FF0, 15, 0, 0, 31, 0, 0};
    vecs[9]  = '{1, 32'h0012_3456,                  32'h0,    0, 0, 2, 0, 0,  32'h0,      1, 32'hCAFE,    32'h0,      32'h0048_D158, 9, 0, 0, 0,  0, 0};
    vecs[10] = '{0, mk(2, 1, 1, 1, 2, 0, 1),        32'h0,    0, 0, 0, 0, 0,  32'h0,      0, 32'h0,       32'hCAFE,   32'h1,       2, 2, 1, 1,  1, 1};
    vecs[11] = '{1, mk(0, 0, 0, 0, 3, 2, 3),        32'h0,    0, 0, 0, 0, 0,  32'h0,      1, 32'h0,       32'hAA,     32'h3,       3, 0, 0, 0,  0, 0};

    drive_idle();
    rst = 1'b1;
    step();
    step();
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset out_rd1", out_rd1, 32'h0);
    check("reset out_imm", out_imm, 32'h0);
    check("reset r0", r0, 32'h0);
    check("reset r1", r1, 32'h0);
    check("reset stall_fd", 32'(stall_fd), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      in_valid = vecs[i].in_valid; inst = vecs[i].inst; pc = vecs[i].pc;
      reg_src_a1 = vecs[i].src_a1; reg_src_a2 = vecs[i].src_a2; imm_src = vecs[i].imm_src;
      reg_write = vecs[i].reg_write; a3 = vecs[i].a3; wd3 = vecs[i].wd3;
      #1;
      check($sformatf("v%0d stall_fd", i), 32'(stall_fd), 32'h0);
      step();
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d out_rd1", i), out_rd1, vecs[i].exp_rd1);
      check($sformatf("v%0d out_rd2", i), out_rd2, vecs[i].exp_rd2);
      check($sformatf("v%0d out_imm", i), out_imm, vecs[i].exp_imm);
      check($sformatf("v%0d out_rd", i), 32'(out_rd), 32'(vecs[i].exp_rd));
      check($sformatf("v%0d out_cond", i), 32'(out_cond), 32'(vecs[i].exp_cond));
      check($sformatf("v%0d out_op", i), 32'(out_op), 32'(vecs[i].exp_op));
      check($sformatf("v%0d out_cmd", i), 32'(out_cmd), 32'(vecs[i].exp_cmd));
      check($sformatf("v%0d out_imm_flag", i), 32'(out_imm_flag), 32'(vecs[i].exp_flag));
      check($sformatf("v%0d out_mem_load", i), 32'(out_mem_load), 32'(vecs[i].exp_load));
    end
    drive_idle();
    check("r1 after writes", r1, 32'hCAFE);
    check("r0 untouched", r0, 32'h0);

    // Load-use: load R4, consumer reads R4, value written back during the bubble.
    drive_dec(mk(0, 1, 0, 1, 4, 0, 0));
    step();
    check("lu load valid", 32'(out_valid), 32'h1);
    check("lu load flag", 32'(out_mem_load), 32'h1);
    drive_dec(mk(0, 0, 0, 0, 9, 4, 0));
    reg_write = 1'b1; a3 = 4'd4; wd3 = 32'h77;
    #1;
    check("lu stall_fd on", 32'(stall_fd), 32'h1);
    step();
    check("lu bubble valid", 32'(out_valid), 32'h0);
    check("lu bubble rd", 32'(out_rd), 32'h0);
    reg_write = 1'b0;
    #1;
    check("lu stall_fd off", 32'(stall_fd), 32'h0);
    step();
    check("lu consumer valid", 32'(out_valid), 32'h1);
    check("lu consumer rd1", out_rd1, 32'h77);
    check("lu consumer rd", 32'(out_rd), 32'h9);

    // ex_stall holds the pipeline register for three cycles.
    drive_dec(mk(0, 0, 0, 0, 10, 0, 0));
    ex_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("hold%0d stall_fd", c), 32'(stall_fd), 32'h1);
      step();
      check($sformatf("hold%0d valid", c), 32'(out_valid), 32'h1);
      check($sformatf("hold%0d rd", c), 32'(out_rd), 32'h9);
      check($sformatf("hold%0d rd1", c), out_rd1, 32'h77);
    end

    // flush beats ex_stall.
    flush = 1'b1;
    #1;
    check("flush stall_fd", 32'(stall_fd), 32'h0);
    step();
    check("flush valid", 32'(out_valid), 32'h0);
    check("flush rd", 32'(out_rd), 32'h0);
    flush = 1'b0; ex_stall = 1'b0;

    // Reset during a load-use stall.
    drive_dec(mk(0, 1, 0, 1, 4, 0, 0));
    step();
    check("rst load flag", 32'(out_mem_load), 32'h1);
    check("rst r1 before", r1, 32'hCAFE);
    drive_dec(mk(0, 0, 0, 0, 9, 4, 0));
    #1;
    check("rst stall_fd before", 32'(stall_fd), 32'h1);
    rst = 1'b1;
    step();
    check("rst valid", 32'(out_valid), 32'h0);
    check("rst rd1", out_rd1, 32'h0);
    check("rst rd", 32'(out_rd), 32'h0);
    check("rst load", 32'(out_mem_load), 32'h0);
    check("rst r1 cleared", r1, 32'h0);
    rst = 1'b0;
    #1;
    check("rst stall_fd after", 32'(stall_fd), 32'h0);
    step();
    check("post rst valid", 32'(out_valid), 32'h1);
    check("post rst rd1", out_rd1, 32'h0);
    check("post rst rd", 32'(out_rd), 32'h9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipe.md
# decode_stage_pipe

Parametrised pipelined decode stage. It decodes the 32-bit instruction word and reads two operands from an internal 16-entry register file with write-through bypass. It extends the immediate, and registers everything into a decode/execute pipeline register with valid, stall and flush control. A load-use interlock stalls fetch and injects a bubble; the block sits between the fetch and execute stages of the processor pipeline.

## Interface
- N, 32, data/PC width in bits (N ≥ 26)
- PC_REG, 15, register index whose reads return the `pc` input; writes to it are discarded
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  `inst`/`pc` carry a real instruction
- inst  in  32  fields: cond[31:29], op[28:27], immFlag[26], cmd[25:21], Rd[20:17], Rn[16:13], Rs[3:0], imm[25:0]
- pc  in  N  PC of `inst`
- reg_src_a1  in  1  1: A1 = PC_REG, 0: A1 = Rn
- reg_src_a2  in  1  1: A2 = Rd, 0: A2 = Rs
- imm_src  in  2  extension mode
- reg_write  in  1  writeback enable
- a3  in  4  writeback address
- wd3  in  N  writeback data
- ex_stall  in  1  execute cannot accept; hold pipeline register
- flush  in  1  kill the instruction being decoded
- a1, a2  out  4  combinational read addresses (to hazard/forwarding logic)
- stall_fd  out  1  combinational; fetch must hold `inst`/`pc`
- out_valid  out  1  registered; pipeline register holds a real instruction
- out_rd1, out_rd2, out_imm  out  N  registered operands and extended immediate
- out_rd  out  4  registered destination
- out_cond  out  3  registered cond field
- out_op  out  2  registered op field
- out_cmd  out  5  registered cmd field
- out_imm_flag  out  1  registered immFlag field
- out_mem_load  out  1  registered load flag: op==2'b01 and cmd[0]==1
- r0, r1  out  N  combinational contents of registers 0 and 1 (debug)

## Operation
- Register file: 16×N flip-flops. Write on the clk edge when reg_write=1 and a3≠PC_REG.
- Reads are combinational. Reading address PC_REG returns `pc`.
- Write bypass: if reg_write=1, a3≠PC_REG and a3==a1 (or a2), rd1 (or rd2) returns wd3 in the same cycle.
- Immediate extension, zero-padded/sign-extended to N:
  - 00: zero-extend inst[7:0]
  - 01: zero-extend inst[11:0]
  - 10: sign-extend {inst[23:0],2'b00}
  - 11: sign-extend inst[25:0]
- Load-use hazard: load_use = out_valid & out_mem_load & in_valid & ((out_rd==a1 & a1≠PC_REG) | (out_rd==a2 & a2≠PC_REG)).
- Pipeline register update priority on each clk edge:
  1. rst: everything cleared (see below).
  2. flush: out_valid←0; all other out_* fields←0.
  3. ex_stall: all out_* hold their values.
  4. load_use: out_valid←0 (bubble); other fields←0.
  5. Otherwise: load the decoded values; out_valid←in_valid.
- stall_fd = ~flush & (ex_stall | load_use).
- When in_valid=0, fields are still captured, but out_valid=0 and downstream ignores them.

## Timing
- Decode-to-output latency is 1 cycle; throughput is 1 instruction/cycle when there are no stalls.
- Reset: all out_* = 0, out_valid = 0, and all 16 registers = 0 on the first edge with rst=1. r0 and r1 read 0 after that edge.
- rst mid-stall: reset wins; stall_fd depends only on the cleared state afterwards (0 unless ex_stall=1).
- Load-use costs exactly one bubble:
  - The cycle after the bubble, out_valid=0, so load_use=0.
  - The held instruction then issues, with its operand forwarded downstream or read via bypass.
- Simultaneous flush and ex_stall: flush wins; the register clears and stall_fd=0.
- Simultaneous write and read of the same register: the read sees the new value (bypass). The file itself updates at the edge.
- a3==PC_REG with reg_write=1: no state change and no bypass.

## Test plan
- Reset, then write R3=0x0000_00AA (reg_write=1, a3=3). On the next cycle decode with Rn=3, reg_src_a1=0 → after 1 cycle out_rd1=0xAA and out_valid=1.
- Same-cycle bypass: reg_write=1, a3=5, wd3=0x1234, decoding Rs=5 with reg_src_a2=0 → out_rd2=0x1234 on the next edge.
- PC read: reg_src_a1=1, pc=0x100 → out_rd1=0x100. A write with a3=15, wd3=0xFF leaves the subsequent PC read at the pc value.
- Immediate modes: inst[25:0]=26'h3FF_FFF0:
  - imm_src=11 → out_imm=0xFFFF_FFF0
  - imm_src=10 → 0xFFFF_FFC0
  - imm_src=00 → 0x0000_00F0
- Load-use: load (op=01, cmd[0]=1, Rd=4) followed by an instruction with Rn=4 → stall_fd=1 for one cycle, one out_valid=0 bubble, then the consumer appears with out_valid=1.
- Control priority:
  - ex_stall=1 for 3 cycles → outputs frozen and stall_fd=1.
  - flush with ex_stall=1 → out_valid=0 next cycle and stall_fd=0.
  - rst asserted during a load-use stall → all outputs 0 next cycle.
